// File: rtl/mux_64to1_tree8_if.sv
// Bundle for the 64:1 tree selector: input lanes, lane select and valid in,
// selected lane and valid out.
interface mux_64to1_tree8_if #(
   parameter int WIDTH = 1
);
   logic [64*WIDTH-1:0] a;
   logic [5:0]          s;
   logic                in_valid;
   logic [WIDTH-1:0]    y;
   logic                out_valid;

   modport master (output a, s, in_valid, input y, out_valid);
   modport slave  (input a, s, in_valid, output y, out_valid);
endinterface

// File: rtl/mux_64to1_tree8.sv
// Registered 64:1 lane selector built from nine 8:1 cells: eight leaves on
// s[2:0], one root on s[5:3], with an optional register between the levels.
module mux8_cell #(
   parameter int WIDTH = 1
) (
   input  logic [8*WIDTH-1:0] d,
   input  logic [2:0]         sel,
   output logic [WIDTH-1:0]   y
);
   always_comb begin
      y = '0;
      case (sel)
         3'd0: y = d[0*WIDTH +: WIDTH];
         3'd1: y = d[1*WIDTH +: WIDTH];
         3'd2: y = d[2*WIDTH +: WIDTH];
         3'd3: y = d[3*WIDTH +: WIDTH];
         3'd4: y = d[4*WIDTH +: WIDTH];
         3'd5: y = d[5*WIDTH +: WIDTH];
         3'd6: y = d[6*WIDTH +: WIDTH];
         3'd7: y = d[7*WIDTH +: WIDTH];
      endcase
   end
endmodule

module mux_64to1_tree8 #(
   parameter int WIDTH    = 1,
   parameter int PIPE_MID = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mux_64to1_tree8_if.slave     bus
);
   logic [8*WIDTH-1:0] leaf_p0;
   logic [8*WIDTH-1:0] leaf_p1;
   logic [2:0]         sel_hi_p1;
   logic               vld_p1;
   logic [WIDTH-1:0]   root_p1;

   logic [WIDTH-1:0]   y_d, y_q;
   logic               vld_p2_d, vld_p2_q;

   // Stage p0: leaf cells on s[2:0]; stage p1: root cell on s[5:3]
   for (genvar g = 0; g < 9; g++) begin : g_cell
      if (g < 8) begin : g_leaf
         mux8_cell #(.WIDTH(WIDTH)) u_cell (
            .d   (bus.a[g*8*WIDTH +: 8*WIDTH]),
            .sel (bus.s[2:0]),
            .y   (leaf_p0[g*WIDTH +: WIDTH])
         );
      end else begin : g_root
         mux8_cell #(.WIDTH(WIDTH)) u_cell (
            .d   (leaf_p1),
            .sel (sel_hi_p1),
            .y   (root_p1)
         );
      end
   end

   // Mid-tree boundary: the root select and valid travel with the leaf data
   if (PIPE_MID != 0) begin : g_mid
      logic [8*WIDTH-1:0] leaf_d, leaf_q;
      logic [2:0]         sel_hi_d, sel_hi_q;
      logic               vld_p1_d, vld_p1_q;

      always_comb begin
         leaf_d   = leaf_p0;
         sel_hi_d = bus.s[5:3];
         vld_p1_d = bus.in_valid;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            leaf_q   <= '0;
            sel_hi_q <= '0;
            vld_p1_q <= 1'b0;
         end else begin
            leaf_q   <= leaf_d;
            sel_hi_q <= sel_hi_d;
            vld_p1_q <= vld_p1_d;
         end
      end

      assign leaf_p1   = leaf_q;
      assign sel_hi_p1 = sel_hi_q;
      assign vld_p1    = vld_p1_q;
   end else begin : g_direct
      assign leaf_p1   = leaf_p0;
      assign sel_hi_p1 = bus.s[5:3];
      assign vld_p1    = bus.in_valid;
   end

   // Output boundary: y reloads every cycle; out_valid qualifies it
   always_comb begin
      y_d      = root_p1;
      vld_p2_d = vld_p1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q      <= '0;
         vld_p2_q <= 1'b0;
      end else begin
         y_q      <= y_d;
         vld_p2_q <= vld_p2_d;
      end
   end

   assign bus.y         = y_q;
   assign bus.out_valid = vld_p2_q;
endmodule

// File: tb/tb_mux_64to1_tree8.sv
// Directed bench for mux_64to1_tree8: WIDTH=1 with PIPE_MID=0 and 1 side by
// side, plus a WIDTH=8 PIPE_MID=1 instance for the wide-lane sweep.
module tb_mux_64to1_tree8;
   logic clk = 1'b0;
   logic rst_n;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mux_64to1_tree8_if #(.WIDTH(1)) bus0 ();
   mux_64to1_tree8_if #(.WIDTH(1)) bus1 ();
   mux_64to1_tree8_if #(.WIDTH(8)) bus8 ();

   mux_64to1_tree8 #(.WIDTH(1), .PIPE_MID(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   mux_64to1_tree8 #(.WIDTH(1), .PIPE_MID(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   mux_64to1_tree8 #(.WIDTH(8), .PIPE_MID(1)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

   task automatic drive1(input logic [63:0] a, input logic [5:0] s, input logic v);
      @(negedge clk);
      bus0.a = a; bus0.s = s; bus0.in_valid = v;
      bus1.a = a; bus1.s = s; bus1.in_valid = v;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus0.a = '0; bus0.s = '0; bus0.in_valid = 1'b0;
      bus1.a = '0; bus1.s = '0; bus1.in_valid = 1'b0;
      bus8.a = '0; bus8.s = '0; bus8.in_valid = 1'b0;
      #2;
      n_vec++; if ({bus0.out_valid, bus0.y} !== 2'b00) begin n_err++; $display("FAIL reset0_init got %b want 00", {bus0.out_valid, bus0.y}); end
      n_vec++; if ({bus1.out_valid, bus1.y} !== 2'b00) begin n_err++; $display("FAIL reset1_init got %b want 00", {bus1.out_valid, bus1.y}); end
      n_vec++; if ({bus8.out_valid, bus8.y} !== 9'h000) begin n_err++; $display("FAIL reset8_init got %h want 000", {bus8.out_valid, bus8.y}); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_reset_midstream();
      drive1({64{1'b1}}, 6'd0, 1'b1);
      bus8.a = {512{1'b1}}; bus8.s = 6'd0; bus8.in_valid = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      n_vec++; if ({bus1.out_valid, bus1.y} !== 2'b11) begin n_err++; $display("FAIL pre_reset1 got %b want 11", {bus1.out_valid, bus1.y}); end
      n_vec++; if ({bus8.out_valid, bus8.y} !== 9'h1ff) begin n_err++; $display("FAIL pre_reset8 got %h want 1ff", {bus8.out_valid, bus8.y}); end
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if ({bus0.out_valid, bus0.y} !== 2'b00) begin n_err++; $display("FAIL async_reset0 got %b want 00", {bus0.out_valid, bus0.y}); end
      n_vec++; if ({bus1.out_valid, bus1.y} !== 2'b00) begin n_err++; $display("FAIL async_reset1 got %b want 00", {bus1.out_valid, bus1.y}); end
      n_vec++; if ({bus8.out_valid, bus8.y} !== 9'h000) begin n_err++; $display("FAIL async_reset8 got %h want 000", {bus8.out_valid, bus8.y}); end
      @(posedge clk);
      drive1({64{1'b1}}, 6'd0, 1'b0);
      bus8.in_valid = 1'b0;
      rst_n = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         n_vec++; if (bus0.out_valid !== 1'b0) begin n_err++; $display("FAIL flush0 c%0d got %b want 0", c, bus0.out_valid); end
         n_vec++; if (bus1.out_valid !== 1'b0) begin n_err++; $display("FAIL flush1 c%0d got %b want 0", c, bus1.out_valid); end
         n_vec++; if (bus8.out_valid !== 1'b0) begin n_err++; $display("FAIL flush8 c%0d got %b want 0", c, bus8.out_valid); end
      end
   endtask

   task automatic test_onehot_walk();
      int ks[10] = '{0, 1, 2, 5, 10, 32, 60, 61, 62, 63};
      for (int i = 0; i < 10; i++) begin
         drive1(64'd1 << ks[i], 6'(ks[i]), 1'b1);
         @(posedge clk); #1;
         n_vec++; if ({bus0.out_valid, bus0.y} !== 2'b11) begin n_err++; $display("FAIL walk0 k=%0d got %b want 11", ks[i], {bus0.out_valid, bus0.y}); end
         @(posedge clk); #1;
         n_vec++; if ({bus1.out_valid, bus1.y} !== 2'b11) begin n_err++; $display("FAIL walk1 k=%0d got %b want 11", ks[i], {bus1.out_valid, bus1.y}); end
      end
   endtask

   task automatic test_mismatch();
      logic [63:0] av[3] = '{64'd1 << 5, ~(64'd1 << 40), ~(64'd1 << 40)};
      logic [5:0]  sv[3] = '{6'd6, 6'd40, 6'd41};
      logic        ev[3] = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         drive1(av[i], sv[i], 1'b1);
         @(posedge clk); #1;
         n_vec++; if ({bus0.out_valid, bus0.y} !== {1'b1, ev[i]}) begin n_err++; $display("FAIL mismatch0 s=%0d got %b want %b", sv[i], {bus0.out_valid, bus0.y}, {1'b1, ev[i]}); end
         @(posedge clk); #1;
         n_vec++; if ({bus1.out_valid, bus1.y} !== {1'b1, ev[i]}) begin n_err++; $display("FAIL mismatch1 s=%0d got %b want %b", sv[i], {bus1.out_valid, bus1.y}, {1'b1, ev[i]}); end
      end
   endtask

   task automatic test_leaf_boundary();
      logic [63:0] av[3] = '{64'd1 << 7, 64'd1 << 7, 64'd1 << 56};
      logic [5:0]  sv[3] = '{6'd7, 6'd8, 6'd56};
      logic        ev[3] = '{1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         drive1(av[i], sv[i], 1'b1);
         @(posedge clk); #1;
         n_vec++; if ({bus0.out_valid, bus0.y} !== {1'b1, ev[i]}) begin n_err++; $display("FAIL leaf0 s=%0d got %b want %b", sv[i], {bus0.out_valid, bus0.y}, {1'b1, ev[i]}); end
         @(posedge clk); #1;
         n_vec++; if ({bus1.out_valid, bus1.y} !== {1'b1, ev[i]}) begin n_err++; $display("FAIL leaf1 s=%0d got %b want %b", sv[i], {bus1.out_valid, bus1.y}, {1'b1, ev[i]}); end
      end
   endtask

   task automatic test_no_hold();
      drive1(64'd1 << 3, 6'd3, 1'b0);
      @(posedge clk); #1;
      n_vec++; if ({bus0.out_valid, bus0.y} !== 2'b01) begin n_err++; $display("FAIL nohold0 got %b want 01", {bus0.out_valid, bus0.y}); end
      @(posedge clk); #1;
      n_vec++; if ({bus1.out_valid, bus1.y} !== 2'b01) begin n_err++; $display("FAIL nohold1 got %b want 01", {bus1.out_valid, bus1.y}); end
   endtask

   task automatic test_back_to_back();
      logic        exp_q[64];
      logic [63:0] a_t;
      logic [5:0]  s_t;
      for (int i = 0; i <= 64; i++) begin
         if (i < 64) begin
            a_t = {$urandom, $urandom};
            s_t = 6'(i * 37);
            exp_q[i] = a_t[s_t];
            drive1(a_t, s_t, 1'b1);
         end else begin
            drive1('0, 6'd0, 1'b0);
         end
         @(posedge clk); #1;
         if (i < 64) begin
            n_vec++; if ({bus0.out_valid, bus0.y} !== {1'b1, exp_q[i]}) begin n_err++; $display("FAIL b2b0 req%0d got %b want %b", i, {bus0.out_valid, bus0.y}, {1'b1, exp_q[i]}); end
         end else begin
            n_vec++; if (bus0.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b0_tail got %b want 0", bus0.out_valid); end
         end
         if (i >= 1) begin
            n_vec++; if ({bus1.out_valid, bus1.y} !== {1'b1, exp_q[i-1]}) begin n_err++; $display("FAIL b2b1 req%0d got %b want %b", i - 1, {bus1.out_valid, bus1.y}, {1'b1, exp_q[i-1]}); end
         end
      end
   endtask

   task automatic test_wide_sweep();
      logic [7:0] exp_y;
      drive1('0, 6'd0, 1'b0);
      for (int k = 0; k < 64; k++) bus8.a[k*8 +: 8] = 8'(k) ^ 8'hA5;
      for (int i = 0; i <= 64; i++) begin
         @(negedge clk);
         bus8.s        = 6'(i);
         bus8.in_valid = (i < 64);
         @(posedge clk); #1;
         if (i >= 1) begin
            exp_y = 8'(i - 1) ^ 8'hA5;
            n_vec++; if ({bus8.out_valid, bus8.y} !== {1'b1, exp_y}) begin n_err++; $display("FAIL wide s=%0d got %h want %h", i - 1, {bus8.out_valid, bus8.y}, {1'b1, exp_y}); end
         end
      end
      @(negedge clk); bus8.in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_reset_midstream();
      test_onehot_walk();
      test_mismatch();
      test_leaf_boundary();
      test_no_hold();
      test_back_to_back();
      test_wide_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
